// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: Q3.12 angle table, gain and quadrant constants, FSM state type.
package cordic_pkg;

  localparam int unsigned ANG_W = 16;
  localparam int unsigned K_W   = 12;

  localparam logic [K_W-1:0]          K_GAIN  = 12'd2487;
  localparam logic signed [ANG_W-1:0] HALF_PI = 16'sd6434;
  localparam logic signed [ANG_W-1:0] PI      = 16'sd12868;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ROTATE,
    S_SCALE,
    S_DONE
  } state_t;

  // round(atan(2^-i) * 2^12); entries past i=12 round to zero
  function automatic logic signed [ANG_W-1:0] atan_q(input logic [4:0] i);
    case (i)
      5'd0:    atan_q = 16'sd3217;
      5'd1:    atan_q = 16'sd1899;
      5'd2:    atan_q = 16'sd1003;
      5'd3:    atan_q = 16'sd509;
      5'd4:    atan_q = 16'sd256;
      5'd5:    atan_q = 16'sd128;
      5'd6:    atan_q = 16'sd64;
      5'd7:    atan_q = 16'sd32;
      5'd8:    atan_q = 16'sd16;
      5'd9:    atan_q = 16'sd8;
      5'd10:   atan_q = 16'sd4;
      5'd11:   atan_q = 16'sd2;
      5'd12:   atan_q = 16'sd1;
      default: atan_q = 16'sd0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_pol2cart_gain_mul.sv
// Combinational signed x unsigned multiplier used to remove the CORDIC gain.
module cordic_pol2cart_gain_mul #(
  parameter int unsigned A_W = 18,
  parameter int unsigned K_W = 12
) (
  input  logic signed [A_W-1:0]   a,
  input  logic        [K_W-1:0]   k,
  output logic signed [A_W+K_W:0] p
);

  // k is zero-extended so the product stays a signed multiply
  always_comb begin
    p = $signed({{(K_W+1){a[A_W-1]}}, a}) * $signed({{(A_W+1){1'b0}}, k});
  end

endmodule

// File: rtl/cordic_pol2cart.sv
// Iterative polar-to-cartesian CORDIC; one micro-rotation per clock.
// Gain compensation (SCALE state + multipliers) enabled by CORDIC_POL2CART_GAIN_COMP_EN.
module cordic_pol2cart
  import cordic_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ITER   = 12
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst_n,
  input  logic                     ap_start,
  output logic                     ap_ready,
  output logic                     ap_idle,
  output logic                     ap_done,
  input  logic signed [DATA_W-1:0] r,
  input  logic signed [DATA_W-1:0] theta,
  output logic signed [DATA_W-1:0] x,
  output logic signed [DATA_W-1:0] y
);

  localparam int unsigned AW = DATA_W + 2;
  localparam int unsigned ZW = ANG_W + 2;
  localparam int unsigned CW = $clog2(ITER);
  localparam int unsigned PW = AW + K_W + 1;

  localparam logic signed [PW-1:0] SAT_HI = $signed({{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [PW-1:0] SAT_LO = ~SAT_HI;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic signed [AW-1:0]   xr, yr;
  logic signed [ZW-1:0]   zr;

  logic signed [ANG_W-1:0] theta_q;
  logic signed [AW-1:0]    r_ext, x0, y0, xs, ys, xn, yn;
  logic signed [ZW-1:0]    z0, ang, zn;

  function automatic logic signed [DATA_W-1:0] sat(input logic signed [PW-1:0] v);
    if (v > SAT_HI)      return SAT_HI[DATA_W-1:0];
    else if (v < SAT_LO) return SAT_LO[DATA_W-1:0];
    else                 return v[DATA_W-1:0];
  endfunction

  // Bring theta from Q3.(DATA_W-4) onto the Q3.12 grid of the angle table
  if (DATA_W >= ANG_W) begin : g_th_dn
    assign theta_q = ANG_W'(theta >>> (DATA_W - ANG_W));
  end else begin : g_th_up
    assign theta_q = ANG_W'(theta) <<< (ANG_W - DATA_W);
  end

  // Quadrant pre-rotation so the residual angle lies within +/-pi/2
  always_comb begin
    r_ext = AW'(r);
    x0    = r_ext;
    y0    = '0;
    z0    = ZW'(theta_q);
    if (theta_q > HALF_PI) begin
      x0 = '0;
      y0 = r_ext;
      z0 = ZW'(theta_q) - ZW'(HALF_PI);
    end else if (theta_q < -HALF_PI) begin
      x0 = '0;
      y0 = -r_ext;
      z0 = ZW'(theta_q) + ZW'(HALF_PI);
    end
  end

  always_comb begin
    xs  = xr >>> cnt;
    ys  = yr >>> cnt;
    ang = ZW'(atan_q(5'(cnt)));
    xn  = xr - ys;
    yn  = yr + xs;
    zn  = zr - ang;
    if (zr[ZW-1]) begin
      xn = xr + ys;
      yn = yr - xs;
      zn = zr + ang;
    end
  end

`ifdef CORDIC_POL2CART_GAIN_COMP_EN
  logic signed [PW-1:0] px, py;

  cordic_pol2cart_gain_mul #(.A_W(AW), .K_W(K_W)) u_mul_x (
    .a (xr),
    .k (K_GAIN),
    .p (px)
  );

  cordic_pol2cart_gain_mul #(.A_W(AW), .K_W(K_W)) u_mul_y (
    .a (yr),
    .k (K_GAIN),
    .p (py)
  );
`endif

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state    <= S_IDLE;
      ap_ready <= 1'b0;
      ap_done  <= 1'b0;
      ap_idle  <= 1'b1;
      x        <= '0;
      y        <= '0;
      cnt      <= '0;
      xr       <= '0;
      yr       <= '0;
      zr       <= '0;
    end else begin
      ap_ready <= 1'b0;
      ap_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ap_start) begin
            xr       <= x0;
            yr       <= y0;
            zr       <= z0;
            cnt      <= '0;
            ap_ready <= 1'b1;
            ap_idle  <= 1'b0;
            state    <= S_ROTATE;
          end
        end
        S_ROTATE: begin
          xr <= xn;
          yr <= yn;
          zr <= zn;
          if (cnt == CW'(ITER - 1)) begin
            cnt <= '0;
`ifdef CORDIC_POL2CART_GAIN_COMP_EN
            state <= S_SCALE;
`else
            x       <= sat(PW'(xn));
            y       <= sat(PW'(yn));
            ap_done <= 1'b1;
            state   <= S_DONE;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef CORDIC_POL2CART_GAIN_COMP_EN
        S_SCALE: begin
          x       <= sat(px >>> K_W);
          y       <= sat(py >>> K_W);
          ap_done <= 1'b1;
          state   <= S_DONE;
        end
`endif
        S_DONE: begin
          ap_idle <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          ap_idle <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_pol2cart.sv
// Directed-vector bench for cordic_pol2cart; expectations follow CORDIC_POL2CART_GAIN_COMP_EN.
module tb_cordic_pol2cart;

  localparam int DATA_W = 16;
  localparam int ITER   = 12;
`ifdef CORDIC_POL2CART_GAIN_COMP_EN
  localparam int LAT = ITER + 2;
`else
  localparam int LAT = ITER + 1;
`endif
  localparam int PER = LAT + 1;
  localparam int NV  = 10;

  logic ap_clk = 1'b0;
  logic ap_rst_n, ap_start, ap_ready, ap_idle, ap_done;
  logic signed [DATA_W-1:0] r, theta, x, y;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string name;
    int    r;
    int    theta;
    int    ex;
    int    ey;
    int    tolx;
    int    toly;
  } vec_t;

  vec_t vecs[NV];

  cordic_pol2cart #(.DATA_W(DATA_W), .ITER(ITER)) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .ap_start (ap_start),
    .ap_ready (ap_ready),
    .ap_idle  (ap_idle),
    .ap_done  (ap_done),
    .r        (r),
    .theta    (theta),
    .x        (x),
    .y        (y)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp, input int tol);
    int d;
    d = act - exp;
    if (d < 0) d = -d;
    n_cmp++;
    if (d > tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (+/-%0d)", name, act, exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ap_idle && n < 50) begin
      tick();
      n++;
    end
    if (!ap_idle) chk("wait_idle", int'(ap_idle), 1, 0);
  endtask

  task automatic convert(input int rv, input int tv, output int xo, output int yo,
                         output int done_cyc, output int n_ready, output int n_done);
    int c;
    wait_idle();
    r        = DATA_W'(rv);
    theta    = DATA_W'(tv);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    r        = DATA_W'($urandom);
    theta    = DATA_W'($urandom);
    c        = 1;
    done_cyc = -1;
    n_ready  = 0;
    n_done   = 0;
    xo       = 0;
    yo       = 0;
    while (c <= LAT + 6) begin
      if (ap_ready) n_ready++;
      if (ap_done) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          xo       = int'(x);
          yo       = int'(y);
        end
      end
      tick();
      c++;
    end
  endtask

  initial begin
    int xo, yo, dc, nr, nd, c;
    int rdy_q[$];
    int dn_q[$];
    int dx_q[$];

`ifdef CORDIC_POL2CART_GAIN_COMP_EN
    vecs[0] = '{"th0",     8192,      0,   8192,      0, 8,  8};
    vecs[1] = '{"pi2",     8192,   6434,      0,   8192, 8,  8};
    vecs[2] = '{"pi4",     8192,   3217,   5793,   5793, 8,  8};
    vecs[3] = '{"pi",      8192,  12868,  -8192,      0, 8,  8};
    vecs[4] = '{"mpi",     8192, -12868,  -8192,      0, 8,  8};
    vecs[5] = '{"neg_r",  -8192,      0,  -8192,      0, 8,  8};
    vecs[6] = '{"r15",    12288,  -3217,   8688,  -8688, 8,  8};
    vecs[7] = '{"mpi2",    8192,  -6434,      0,  -8192, 8,  8};
    vecs[8] = '{"big",    24576,      0,  24573,      0, 16, 16};
    vecs[9] = '{"bigneg",-24576,      0, -24573,      0, 16, 16};
`else
    vecs[0] = '{"th0",     8192,      0,  13490,      0, 8,  8};
    vecs[1] = '{"pi2",     8192,   6434,      0,  13490, 8,  8};
    vecs[2] = '{"pi4",     8192,   3217,   9539,   9539, 8,  8};
    vecs[3] = '{"pi",      8192,  12868, -13490,      0, 8,  8};
    vecs[4] = '{"mpi",     8192, -12868, -13490,      0, 8,  8};
    vecs[5] = '{"neg_r",  -8192,      0, -13490,      0, 8,  8};
    vecs[6] = '{"r15",    12288,  -3217,  14308, -14308, 8,  8};
    vecs[7] = '{"mpi2",    8192,  -6434,      0, -13490, 8,  8};
    vecs[8] = '{"big",    24576,      0,  32767,      0, 0, 16};
    vecs[9] = '{"bigneg",-24576,      0, -32768,      0, 0, 16};
`endif

    // Reset state
    ap_rst_n = 1'b0;
    ap_start = 1'b0;
    r        = '0;
    theta    = '0;
    repeat (3) tick();
    chk("rst_idle",  int'(ap_idle),  1, 0);
    chk("rst_ready", int'(ap_ready), 0, 0);
    chk("rst_done",  int'(ap_done),  0, 0);
    chk("rst_x",     int'(x),        0, 0);
    chk("rst_y",     int'(y),        0, 0);
    ap_rst_n = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      convert(vecs[i].r, vecs[i].theta, xo, yo, dc, nr, nd);
      chk({vecs[i].name, "_lat"},   dc, LAT, 0);
      chk({vecs[i].name, "_x"},     xo, vecs[i].ex, vecs[i].tolx);
      chk({vecs[i].name, "_y"},     yo, vecs[i].ey, vecs[i].toly);
      chk({vecs[i].name, "_nrdy"},  nr, 1, 0);
      chk({vecs[i].name, "_ndone"}, nd, 1, 0);
    end

    // ap_start held high for 40 cycles: back-to-back acceptance
    wait_idle();
    r        = DATA_W'(8192);
    theta    = '0;
    ap_start = 1'b1;
    c        = 0;
    while (c < 70) begin
      if (ap_ready) rdy_q.push_back(c);
      if (ap_done) begin
        dn_q.push_back(c);
        dx_q.push_back(int'(x));
      end
      tick();
      c++;
      if (c == 40) ap_start = 1'b0;
    end
    chk("b2b_nrdy",  rdy_q.size(), 3, 0);
    chk("b2b_ndone", dn_q.size(),  3, 0);
    for (int k = 0; k < 3; k++) begin
      if (k < rdy_q.size()) chk($sformatf("b2b_rdy%0d", k), rdy_q[k], k*PER + 1, 0);
      else                  chk($sformatf("b2b_rdy%0d", k), -1,       k*PER + 1, 0);
      if (k < dn_q.size()) begin
        chk($sformatf("b2b_done%0d", k), dn_q[k], k*PER + LAT, 0);
        chk($sformatf("b2b_x%0d", k),    dx_q[k], vecs[0].ex, 8);
      end else begin
        chk($sformatf("b2b_done%0d", k), -1, k*PER + LAT, 0);
      end
    end

    // Reset asserted in cycle 5 of a conversion
    wait_idle();
    r        = DATA_W'(8192);
    theta    = DATA_W'(3217);
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    nd = 0;
    for (int k = 1; k < 5; k++) begin
      if (ap_done) nd++;
      tick();
    end
    ap_rst_n = 1'b0;
    tick();
    chk("abort_idle",  int'(ap_idle),  1, 0);
    chk("abort_x",     int'(x),        0, 0);
    chk("abort_y",     int'(y),        0, 0);
    chk("abort_ready", int'(ap_ready), 0, 0);
    ap_rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      if (ap_done) nd++;
      tick();
    end
    chk("abort_nodone", nd, 0, 0);

    // Recovery after abort
    convert(vecs[2].r, vecs[2].theta, xo, yo, dc, nr, nd);
    chk("recov_lat", dc, LAT, 0);
    chk("recov_x",   xo, vecs[2].ex, 8);
    chk("recov_y",   yo, vecs[2].ey, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_pol2cart.md
CORDIC_POL2CART -- requirements
Module: cordic_pol2cart

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of r, theta, x, y.
REQ-002 SHALL have parameter ITER, default 12, legal range 8..DATA_W-2: number of CORDIC micro-rotations.
REQ-003 SHALL have port ap_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port ap_rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port ap_start, input, 1: request a conversion.
REQ-006 SHALL have port ap_ready, output, 1: one-cycle pulse when r/theta are latched.
REQ-007 SHALL have port ap_idle, output, 1: high while in IDLE.
REQ-008 SHALL have port ap_done, output, 1: one-cycle pulse when x/y become valid.
REQ-009 SHALL have port r, input, DATA_W: signed magnitude, Q2.(DATA_W-3).
REQ-010 SHALL have port theta, input, DATA_W: signed radians, Q3.(DATA_W-4); legal range [-pi, +pi].
REQ-011 SHALL have port x, output, DATA_W: signed r*cos(theta), same format as r.
REQ-012 SHALL have port y, output, DATA_W: signed r*sin(theta), same format as r.

Function
REQ-013 SHALL implement FSM IDLE -> ROTATE -> SCALE -> DONE -> IDLE.
REQ-014 SHALL sample ap_start only in IDLE; on ap_start=1 it latches r/theta, pulses ap_ready and enters ROTATE.
REQ-015 SHALL apply quadrant pre-rotation at latch time: theta>pi/2 -> (x0,y0,z0)=(0,r,theta-pi/2); theta<-pi/2 -> (0,-r,theta+pi/2); otherwise (r,0,theta).
REQ-016 SHALL perform one micro-rotation per cycle for i=0..ITER-1, using d=+1 if z>=0 else -1: x'=x-d*(y>>>i), y'=y+d*(x>>>i), z'=z-d*atan(2^-i).
REQ-017 SHALL hold x/y datapath registers at DATA_W+2 bits, with arithmetic shifts and no intermediate truncation.
REQ-018 SHALL, in SCALE, multiply x and y by unsigned gain constant K=round(0.607252935*2^12), arithmetic-shift right by 12 and saturate to DATA_W.
REQ-019 SHALL assert ap_done in DONE for exactly one cycle, exactly ITER+2 cycles after the cycle in which ap_start was accepted, then return to IDLE.
REQ-020 SHALL hold x/y stable from ap_done until the next ap_done.
REQ-021 SHALL ignore ap_start while not IDLE; if ap_start is still high on return to IDLE, it SHALL accept it in that cycle (back-to-back period ITER+3).
REQ-022 SHALL leave r/theta changes after acceptance without effect on the current conversion.
REQ-023 SHALL produce results with error <= 8 LSB versus ideal at DATA_W=16, ITER=12, |r|<=1.5.

Reset
REQ-024 SHALL, while ap_rst_n=0 at a clock edge, set FSM=IDLE, ap_ready=0, ap_done=0, ap_idle=1, x=0, y=0 and iteration counter=0.
REQ-025 SHALL abort a conversion on reset mid-operation, with no ap_done and outputs cleared to 0.

Configuration
REQ-026 SHALL use macro CORDIC_POL2CART_GAIN_COMP_EN: when defined, SCALE is present as in REQ-018 and latency is ITER+2.
REQ-027 SHALL, without CORDIC_POL2CART_GAIN_COMP_EN, skip SCALE: x/y are the saturated unscaled CORDIC outputs (gain ~1.6468), latency is ITER+1 and the multiplier is not instantiated.

Structure
REQ-028 SHALL take from shared package cordic_pkg: the atan(2^-i) table in Q3.12, constants K_GAIN (2487), HALF_PI (6434) and PI (12868) in Q3.12, and the FSM state enum.
REQ-029 SHALL instantiate sub-module cordic_pol2cart_gain_mul (signed DATA_W+2 x unsigned 12-bit, combinational), twice or time-shared, inside SCALE.

Verification (DATA_W=16, ITER=12, GAIN_COMP_EN defined; tolerance +/-8 LSB)
REQ-030 SHALL cover: r=8192, theta=0 -> ap_done at cycle 14, x~8192, y~0.
REQ-031 SHALL cover: r=8192, theta=6434 (pi/2) -> x~0, y~8192; theta=3217 (pi/4) -> x~y~5793.
REQ-032 SHALL cover: r=8192, theta=12868 (pi) -> x~-8192, y~0; theta=-12868 -> x~-8192, y~0.
REQ-033 SHALL cover: ap_start held high for 40 cycles -> accepts at cycles 0, 15, 30, with exactly one ap_ready and one ap_done per conversion.
REQ-034 SHALL cover: ap_rst_n=0 at cycle 5 of a conversion -> no ap_done, x=y=0, ap_idle=1 next cycle.
REQ-035 SHALL cover: macro undefined, r=8192, theta=0 -> ap_done at cycle 13, x~13490.
